serial_pattern_scanner: RTL
===========================

SERIAL_PATTERN_SCANNER -- requirements
Module: serial_pattern_scanner

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst, both sampled on the rising edge of clk.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration can be accepted
- cfg_pattern  in  8  pattern bits, bit[len-1] is first received, bit[0] is last
- cfg_len_m1  in  3  pattern length minus 1 (0..7 means length 1..8)
- cfg_limit  in  8  match count that ends a scan; 0 means unlimited
- start  in  1  begin a scan
- abort  in  1  end the current scan
- a_valid  in  1  serial bit present
- a  in  1  serial data bit
- detected  out  1  one-cycle match pulse
- match_count  out  8  matches in the current or last scan, saturating
- busy  out  1  state is SCAN
- done  out  1  state is DONE

Function
REQ-003 The FSM SHALL have four states: IDLE, CFGD (configured), SCAN and DONE.
REQ-004 cfg_ready SHALL be 1 in IDLE, CFGD and DONE, and 0 in SCAN.
REQ-005 A configuration transfer SHALL occur when cfg_valid && cfg_ready; it latches pattern, len_m1 and limit, and the state becomes CFGD.
REQ-006 start in IDLE SHALL be ignored.
REQ-007 start in CFGD or DONE (with no transfer that cycle) SHALL move the state to SCAN and clear history, fill count, match_count and detected.
REQ-008 If cfg_valid and start are both asserted in CFGD or DONE, the configuration SHALL win, the state becomes CFGD, and start is ignored.
REQ-009 In SCAN, each cycle with a_valid=1 SHALL:
- shift the 8-bit history: hist <= {hist[6:0], a};
- increment fill count, saturating at 8.
REQ-010 In cycles with a_valid=0 the history and fill count SHALL hold.
REQ-011 A match SHALL occur on an accepted bit when both hold after the shift:
- new fill count >= len_m1+1;
- the low (len_m1+1) bits of the new history equal the low (len_m1+1) bits of the pattern.
REQ-012 Matches SHALL be allowed to overlap: history is not cleared after a match.
REQ-013 On a match, detected SHALL be registered high for exactly the cycle after the accepted bit (latency 1); otherwise detected is 0.
REQ-014 On a match, match_count SHALL increment on the same edge, saturating at 255.
REQ-015 If limit != 0 and the incremented match_count equals limit, the state SHALL go to DONE on that same edge; the detected pulse is still produced.
REQ-016 In DONE, a_valid SHALL be ignored, match_count holds, and done=1 until start or a configuration transfer.
REQ-017 abort in SCAN SHALL move the state to CFGD with match_count held.
- A bit accepted in the same cycle as abort is discarded: no match, no detected pulse.
REQ-018 abort outside SCAN SHALL be ignored.
REQ-019 busy SHALL equal (state==SCAN) and done SHALL equal (state==DONE); both are decoded from the state register only.
REQ-020 With limit=0, the scan SHALL continue indefinitely, and match_count sticks at 255 once reached.

Reset
REQ-021 On rst, on the next edge, the block SHALL set:
- state = IDLE;
- pattern, len, limit, history and fill count = 0;
- detected = 0, match_count = 0, busy = 0, done = 0;
- cfg_ready = 1.
REQ-022 rst SHALL take priority over all inputs, including mid-scan; the configuration must be reloaded after reset.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Config pattern=8'b00110011, len_m1=5, limit=0; start; stream 1,1,0,0,1,1,0,0,1,1 -> detected pulses the cycle after bit 6 and after bit 10; match_count=2.
- Config pattern=8'b00001010, len_m1=3, limit=2; stream 1,0,1,0,1,0 -> matches after bits 4 and 6; state goes to DONE after bit 6, done=1; further bits leave match_count=2.
- Bits supplied with a_valid gaps: 1,(gap),1,0,(gap),0,1,1 for the 110011 pattern -> exactly one match, detected the cycle after the last valid bit.
- Abort in the same cycle as the completing bit -> no detected pulse, match_count unchanged, state CFGD; a subsequent start clears match_count to 0.
- cfg_valid and start together in DONE -> new configuration latched, state CFGD, busy=0.
- rst asserted mid-scan -> all outputs at reset values next cycle; start before a new configuration is ignored (busy stays 0).

Source files
------------

// File: rtl/serial_pattern_scanner.sv
// serial_pattern_scanner: configurable 1..8-bit serial pattern detector with overlapping matches and a match limit
module serial_pattern_scanner (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_pattern,
  input  logic [2:0] cfg_len_m1,
  input  logic [7:0] cfg_limit,
  input  logic       start,
  input  logic       abort,
  input  logic       a_valid,
  input  logic       a,
  output logic       detected,
  output logic [7:0] match_count,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, CFGD, SCAN, DONE} state_t;
  state_t state;
  logic [7:0] pattern, limit, nh, mask, nc;
  logic [6:0] hist;
  logic [2:0] len_m1;
  logic [3:0] fill, nf;
  logic hit;
  // hist keeps only the 7 newest bits; the incoming bit completes the 8-bit window
  always_comb begin
    nh = {hist, a};
    nf = fill == 4'd8 ? fill : fill + 4'd1;
    mask = 8'hff >> (3'd7 - len_m1);
    hit = nf > {1'b0, len_m1} && ((nh ^ pattern) & mask) == 8'h00;
    nc = match_count == 8'hff ? match_count : match_count + 8'd1;
  end
  assign cfg_ready = state != SCAN;
  assign busy = state == SCAN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pattern <= '0;
      len_m1 <= '0;
      limit <= '0;
      hist <= '0;
      fill <= '0;
      detected <= 1'b0;
      match_count <= '0;
    end else begin
      detected <= 1'b0;
      if (state != SCAN) begin
        if (cfg_valid) begin
          pattern <= cfg_pattern;
          len_m1 <= cfg_len_m1;
          limit <= cfg_limit;
          state <= CFGD;
        end else if (start && state != IDLE) begin
          state <= SCAN;
          hist <= '0;
          fill <= '0;
          match_count <= '0;
        end
      end else if (abort) begin
        state <= CFGD;
      end else if (a_valid) begin
        hist <= nh[6:0];
        fill <= nf;
        if (hit) begin
          detected <= 1'b1;
          match_count <= nc;
          if (limit != 8'h00 && nc == limit) state <= DONE;
        end
      end
    end
  end
endmodule
